// File: rtl/keypad_event_decoder.sv
// Keypad front end: synchronises, debounces and encodes one-hot key lines into queued events.
// Optional auto-repeat of held digit keys is built when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_event_decoder #(
  parameter int unsigned NUM_DIGITS    = 10,
  parameter int unsigned NUM_FUNC      = 2,
  parameter int unsigned DEBOUNCE_CYC  = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned REPEAT_DELAY  = 64,
  parameter int unsigned REPEAT_PERIOD = 16,
  localparam int unsigned NUM_KEYS     = NUM_DIGITS + NUM_FUNC,
  localparam int unsigned NUM_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int unsigned MODE_W       = (NUM_FUNC > 0) ? $clog2(NUM_FUNC + 1) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_KEYS-1:0] sw_sig_i,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [MODE_W-1:0]   evt_mode_o,
  output logic [NUM_W-1:0]    evt_num_o,
  output logic                err_o,
  output logic                ovf_o,
  output logic                busy_o
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned DATA_W = MODE_W + NUM_W;
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  if (DEBOUNCE_CYC < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || NUM_DIGITS < 2 || NUM_FUNC < 1) begin : gBadParams
    $error("keypad_event_decoder: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_e;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  state_e              state_q;
  logic [NUM_KEYS-1:0] cand_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                push_q;
  logic [MODE_W-1:0]   push_mode_q;
  logic [NUM_W-1:0]    push_num_q;
  logic                err_q;

  logic [MODE_W-1:0]   enc_mode;
  logic [NUM_W-1:0]    enc_num;
  logic                cand_onehot;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_sig_i;
      sync2_q <= sync1_q;
    end
  end

  // Event code of the candidate; only meaningful when it is one-hot.
  always_comb begin
    enc_mode = '0;
    enc_num  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (cand_q[i]) begin
        if (i < NUM_DIGITS) enc_num  = NUM_W'(i);
        else                enc_mode = MODE_W'(i - NUM_DIGITS + 1);
      end
    end
  end

  assign cand_onehot = (cand_q != '0) && ((cand_q & (cand_q - 1'b1)) == '0);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_FIRST_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_NEXT_LAST  = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt_q;
  logic             rep_first_q;
  logic             rep_ok_q;
  logic             cand_is_digit;

  assign cand_is_digit = cand_onehot && (cand_q[NUM_DIGITS-1:0] != '0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      push_q      <= 1'b0;
      push_mode_q <= '0;
      push_num_q  <= '0;
      err_q       <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
      rep_ok_q    <= 1'b0;
`endif
    end else begin
      push_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sync2_q != '0) begin
            cand_q  <= sync2_q;
            cnt_q   <= CNT_W'(1);
            state_q <= PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (sync2_q == '0) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (sync2_q != cand_q) begin
            cand_q <= sync2_q;
            cnt_q  <= CNT_W'(1);
          end else if (cnt_q == DB_LAST) begin
            // Accepted: a single key becomes an event, a chord only flags an error.
            if (cand_onehot) begin
              push_q      <= 1'b1;
              push_mode_q <= enc_mode;
              push_num_q  <= enc_num;
            end else begin
              err_q <= 1'b1;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_ok_q <= cand_is_digit;
`endif
            cnt_q   <= '0;
            state_q <= HELD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (sync2_q == '0) begin
            cnt_q   <= CNT_W'(1);
            state_q <= REL_DB;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
          end else if (rep_ok_q) begin
            if (rep_cnt_q == (rep_first_q ? REP_NEXT_LAST : REP_FIRST_LAST)) begin
              push_q      <= 1'b1;
              rep_cnt_q   <= '0;
              rep_first_q <= 1'b1;
            end else begin
              rep_cnt_q <= rep_cnt_q + 1'b1;
            end
`endif
          end
        end
        REL_DB: begin
          if (sync2_q != '0) begin
            cnt_q   <= '0;
            state_q <= HELD;
          end else if (cnt_q == DB_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE);
  assign err_o  = err_q;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q, rptr_d;
  logic [PTR_W:0]    count_q, count_d, count_after_pop;
  logic              valid_q, ovf_q, ovf_d;
  logic [DATA_W-1:0] head_q, head_d, wdata;
  logic              pop, wr;

  assign wdata = {push_mode_q, push_num_q};

  // A push into a full queue only lands when the same edge also pops the head.
  always_comb begin
    pop             = (count_q != '0) && evt_ready_i;
    wr              = push_q && ((count_q != FULL_CNT) || pop);
    ovf_d           = push_q && (count_q == FULL_CNT) && !pop;
    rptr_d          = pop ? rptr_q + 1'b1 : rptr_q;
    count_after_pop = pop ? count_q - 1'b1 : count_q;
    count_d         = wr ? count_after_pop + 1'b1 : count_after_pop;
    head_d          = '0;
    if (count_after_pop == '0) begin
      if (wr) head_d = wdata;
    end else begin
      head_d = mem_q[rptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr) wptr_q <= wptr_q + 1'b1;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= (count_d != '0);
      head_q  <= head_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_valid_o = valid_q;
  assign {evt_mode_o, evt_num_o} = head_q;
  assign ovf_o = ovf_q;

endmodule
